// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM soft-start/soft-stop sequencer.
// Holds the controller state encoding and the saturating duty step rule.
package pwm_ctrl_pkg;

  localparam int PWM_CTRL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RAMP = 2'd2,
    HOLD = 2'd3
  } ctrl_state_e;

  typedef logic [PWM_CTRL_WIDTH-1:0] duty_t;

  // Moves cur one step toward tgt. Lands exactly on tgt when it is within one
  // step, so the result never overshoots and never wraps.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt, input duty_t step);
    duty_t diff;
    if (tgt >= cur) begin
      diff        = tgt - cur;
      step_toward = (diff <= step) ? tgt : duty_t'(cur + step);
    end else begin
      diff        = cur - tgt;
      step_toward = (diff <= step) ? tgt : duty_t'(cur - step);
    end
  endfunction

endpackage

// File: rtl/pwm_dwell_timer.sv
// Counts PWM period ticks and flags the tick on which the dwell limit is reached.
// A zero limit behaves as a limit of one (expire on every tick).
module pwm_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] count;
  logic [DWELL_W:0]   next_count;
  logic [DWELL_W:0]   eff_limit;

  // Compare with >= so a limit lowered mid-count still expires on the next tick.
  always_comb begin
    eff_limit  = (limit == '0) ? (DWELL_W+1)'(1) : {1'b0, limit};
    next_count = {1'b0, count} + (DWELL_W+1)'(1);
    expire     = tick && (next_count >= eff_limit);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= expire ? '0 : next_count[DWELL_W-1:0];
    end else if (clear) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer feeding enable, duty and period of a pwm_generator.
// Duty moves toward the target one step per dwell periods, only on period boundaries.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH   = PWM_CTRL_WIDTH,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               abort,
  input  logic [WIDTH-1:0]   target_duty,
  input  logic [WIDTH-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   period_in,
  input  logic               period_tick,
  output logic               pwm_enable,
  output logic [WIDTH-1:0]   pwm_duty,
  output logic [WIDTH-1:0]   pwm_period,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    ctrl_state_e        state;
    logic [WIDTH-1:0]   tgt;
    logic [WIDTH-1:0]   step;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   duty;
    logic [WIDTH-1:0]   period;
    logic [WIDTH-1:0]   shadow;
    logic               pend;
    logic               enable;
    logic               stopping;
    logic               done;
  } ctrl_t;

  // q: registered context; c: after commands; n: after the period tick.
  ctrl_t            q, c, n;
  logic             busy_q;
  logic             timer_tick;
  logic             timer_clear;
  logic             expire;
  logic [WIDTH-1:0] step_sel;
  logic [WIDTH-1:0] duty_step;

  assign step_sel = (step == '0) ? WIDTH'(1) : step;

  // Command phase: abort > stop > start.
  // NOTE: every field gets a default (c = q) before any branch, so no latches.
  always_comb begin
    c      = q;
    c.done = 1'b0;
    if (abort) begin
      c.state    = IDLE;
      c.duty     = '0;
      c.enable   = 1'b0;
      c.stopping = 1'b0;
      c.pend     = 1'b0;
    end else if (stop && q.state != IDLE) begin
      c.tgt      = '0;
      c.step     = step_sel;
      c.dwell    = dwell;
      c.stopping = 1'b1;
      if (q.duty == '0) begin
        c.state    = IDLE;
        c.enable   = 1'b0;
        c.stopping = 1'b0;
        c.pend     = 1'b0;
        c.done     = 1'b1;
      end else if (q.state == HOLD) begin
        c.state = RAMP;
      end
    end else if (start) begin
      c.tgt      = target_duty;
      c.step     = step_sel;
      c.dwell    = dwell;
      c.stopping = 1'b0;
      if (q.state == IDLE) begin
        c.state  = ARM;
        c.enable = 1'b1;
        c.period = period_in;
      end else begin
        // A running generator only sees a new period at the next wrap.
        c.shadow = period_in;
        c.pend   = 1'b1;
        if (target_duty == q.duty) begin
          c.state = HOLD;
          c.done  = 1'b1;
        end else if (q.state == HOLD) begin
          c.state = RAMP;
        end
      end
    end
  end

  assign timer_tick  = period_tick && (c.state == RAMP);
  assign timer_clear = (q.state != RAMP);

  pwm_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .limit  (c.dwell),
    .expire (expire)
  );

  // Tick phase, evaluated against the post-command state.
  always_comb begin
    n         = c;
    duty_step = step_toward(c.duty, c.tgt, c.step);
    if (period_tick && c.state != IDLE) begin
      if (c.pend) begin
        n.period = c.shadow;
        n.pend   = 1'b0;
      end
      case (c.state)
        ARM: n.state = RAMP;
        RAMP: begin
          if (expire) begin
            n.duty = duty_step;
            if (duty_step == c.tgt) begin
              n.done = 1'b1;
              if (c.stopping) begin
                n.state    = IDLE;
                n.enable   = 1'b0;
                n.stopping = 1'b0;
                n.pend     = 1'b0;
              end else begin
                n.state = HOLD;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      busy_q <= 1'b0;
    end else begin
      q      <= n;
      busy_q <= (n.state == ARM) || (n.state == RAMP);
    end
  end

  assign pwm_enable = q.enable;
  assign pwm_duty   = q.duty;
  assign pwm_period = q.period;
  assign done       = q.done;
  assign busy       = busy_q;

endmodule
